updown_counter_param: RTL and testbench
=======================================

Name: updown_counter_param

Overview:
- Parametrised up/down counter that succeeds the fixed 8-bit increment/decrement counter.
- Adds:
  - configurable width
  - runtime step size
  - programmable upper limit (modulus)
  - wrap or saturate selection
  - count enable
  - terminal-count pulse
  - sticky overflow flag
- Used as a general event/address/timeout counter in datapaths. One clock domain.

Parameters:
- WIDTH, 8, bit width of count, d_in, step, limit (WIDTH >= 2).
- RESET_VAL, 0, value of count after clr. Must be <= the limit in use.

Ports:
- clk  input  1  system clock, rising-edge active.
- clr  input  1  asynchronous, active-high reset.
- en  input  1  count enable. Steps the counter when high and ld is low.
- ld  input  1  synchronous load of d_in. Overrides en.
- mode  input  1  direction: 0 = increment, 1 = decrement.
- d_in  input  WIDTH  load value.
- step  input  WIDTH  increment/decrement amount per enabled cycle.
- limit  input  WIDTH  maximum count value. The legal range is 0..limit.
- sat  input  1  boundary mode: 1 = saturate, 0 = wrap modulo (limit+1).
- ovf_clr  input  1  synchronous clear of the ovf sticky flag.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, one cycle wide per event.
- ovf  output  1  sticky overflow/underflow flag, registered.

Behaviour:
- Reset:
  - When clr = 1, asynchronously: count = RESET_VAL, tc = 0, ovf = 0.
  - These values are held while clr is high.
  - Reset mid-operation discards any pending step or load.
- Priority at each rising clk edge: clr > ld > en. When en = 0 and ld = 0, count holds.
- Effective step: es = (step > limit) ? limit : step. When es = 0, an enabled cycle holds count with no tc and no ovf.
- Load:
  - count <= (d_in > limit) ? limit : d_in.
  - A clamped load sets ovf.
  - A load never asserts tc.
- Out-of-range count (limit lowered below count): an enabled step forces count <= limit and sets ovf, regardless of mode and sat.
- Increment (mode = 0, en = 1, count <= limit):
  - Sum is computed at WIDTH+1 bits: s = count + es.
  - If s <= limit: count <= s.
  - If s > limit and sat = 1: count <= limit, ovf set.
  - If s > limit and sat = 0: count <= s - (limit+1), ovf set.
- Decrement (mode = 1, en = 1, count <= limit):
  - If es <= count: count <= count - es.
  - Else if sat = 1: count <= 0, ovf set.
  - Else: count <= count + (limit+1) - es, computed at WIDTH+1 bits, ovf set.
- All WIDTH+1-bit intermediates truncate to WIDTH only after the range checks. limit = all-ones must work, with modulus 2^WIDTH.
- tc:
  - Registered alongside count, so it is high in the same cycle the new count appears.
  - Set to 1 after an enabled step that wraps, saturates, or lands exactly on the boundary (limit when incrementing, 0 when decrementing). Otherwise 0.
  - When saturated and still enabled, tc is 1 on every further enabled cycle.
- ovf:
  - Set by any wrap, saturation clip, or clamp.
  - Cleared by ovf_clr.
  - When a set event and ovf_clr occur in the same cycle, set wins.
- mode and sat are sampled every cycle. A direction change takes effect on the next edge with no bubble.
- Latency: one clk edge from input to count/tc/ovf. No combinational path from inputs to outputs.

Test Plan:
1. Reset/load: WIDTH = 8, limit = 255. Pulse clr = 1 → count = 0, tc = 0, ovf = 0. Then ld = 1, d_in = 9 → count = 9 after one edge.
2. Increment wrap: limit = 9, sat = 0, step = 1, count = 8, en = 1, mode = 0 → count sequence 9 (tc = 1), 0 (tc = 1, ovf = 1), 1 (tc = 0).
3. Saturate up: limit = 100, sat = 1, step = 7, count = 98, en = 1, mode = 0 → count = 100, tc = 1, ovf = 1. Next edge: count stays 100, tc = 1.
4. Decrement wrap: limit = 9, sat = 0, step = 3, count = 1, mode = 1, en = 1 → count = 8, tc = 1, ovf = 1. Next edge: count = 5, tc = 0.
5. Priority and flag clear: ld = 1 with en = 1, d_in = 200, limit = 150 → count = 150, ovf = 1, tc = 0. Then ovf_clr = 1 alone → ovf = 0. Then ovf_clr = 1 in the same cycle as a wrap → ovf = 1.
6. Async reset mid-count: count running up with step = 1. Assert clr between clock edges → count goes to RESET_VAL immediately, without waiting for an edge. Deassert clr → counting resumes from RESET_VAL on the next enabled edge.

Source files
------------

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with runtime step, programmable limit (modulus),
// wrap/saturate selection, terminal-count pulse and sticky overflow flag.
//
// Ports:
//   clk     - system clock, rising-edge active
//   clr     - asynchronous active-high reset (count = RESET_VAL, tc = 0, ovf = 0)
//   en      - count enable; steps the counter when high and ld is low
//   ld      - synchronous load of d_in (clamped to limit); overrides en
//   mode    - direction: 0 = increment, 1 = decrement
//   d_in    - load value
//   step    - amount added/subtracted per enabled cycle (clamped to limit)
//   limit   - maximum legal count; legal range is 0..limit
//   sat     - 1 = saturate at the boundary, 0 = wrap modulo (limit+1)
//   ovf_clr - synchronous clear of the sticky ovf flag (a set event wins)
//   count   - registered count
//   tc      - registered terminal-count pulse
//   ovf     - registered sticky overflow/underflow flag
module updown_counter_param #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             ld,
    input  logic             mode,
    input  logic [WIDTH-1:0] d_in,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] limit,
    input  logic             sat,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] ResetCount = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] es;
    logic [WIDTH:0]   modulus;
    logic [WIDTH:0]   sum_up;
    logic [WIDTH:0]   wrap_up;
    logic [WIDTH:0]   wrap_dn;
    logic             ovf_set;
    logic             unused_msb;

    // Step larger than the range is clamped so wrap arithmetic stays within one modulus.
    assign es = (step > limit) ? limit : step;

    // Widened by one bit so limit = all-ones gives modulus 2^WIDTH.
    assign modulus = {1'b0, limit} + {{WIDTH{1'b0}}, 1'b1};
    assign sum_up  = {1'b0, count_q} + {1'b0, es};
    assign wrap_up = sum_up - modulus;
    assign wrap_dn = {1'b0, count_q} + modulus - {1'b0, es};

    // Top bits are only needed before truncation.
    assign unused_msb = ^{wrap_up[WIDTH], wrap_dn[WIDTH]};

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_set = 1'b0;

        if (ld) begin
            if (d_in > limit) begin
                count_d = limit;
                ovf_set = 1'b1;
            end else begin
                count_d = d_in;
            end
        end else if (en) begin
            if (count_q > limit) begin
                // Limit was lowered under the count: pull back into range.
                count_d = limit;
                ovf_set = 1'b1;
            end else if (es == '0) begin
                count_d = count_q;
            end else if (!mode) begin
                if (sum_up <= {1'b0, limit}) begin
                    count_d = sum_up[WIDTH-1:0];
                    tc_d    = (sum_up[WIDTH-1:0] == limit);
                end else begin
                    count_d = sat ? limit : wrap_up[WIDTH-1:0];
                    tc_d    = 1'b1;
                    ovf_set = 1'b1;
                end
            end else begin
                if (es <= count_q) begin
                    count_d = count_q - es;
                    tc_d    = (count_q == es);
                end else begin
                    count_d = sat ? '0 : wrap_dn[WIDTH-1:0];
                    tc_d    = 1'b1;
                    ovf_set = 1'b1;
                end
            end
        end

        // Set beats clear when both happen in one cycle.
        ovf_d = ovf_set | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_q <= ResetCount;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
module tb_updown_counter_param;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned RESET_VAL = 0;

    logic             clk;
    logic             clr;
    logic             en;
    logic             ld;
    logic             mode;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] limit;
    logic             sat;
    logic             ovf_clr;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;

    int total;
    int bad;
    bit chk_on;

    updown_counter_param #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .en      (en),
        .ld      (ld),
        .mode    (mode),
        .d_in    (d_in),
        .step    (step),
        .limit   (limit),
        .sat     (sat),
        .ovf_clr (ovf_clr),
        .count   (count),
        .tc      (tc),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model in plain integer arithmetic.
    int m_count;
    bit m_tc;
    bit m_ovf;
    int m_lim, m_es, m_c, m_nxt;
    bit m_set, m_t;

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_count = RESET_VAL;
            m_tc    = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            m_lim = int'(limit);
            m_es  = (int'(step) < m_lim) ? int'(step) : m_lim;
            m_c   = m_count;
            m_nxt = m_c;
            m_set = 1'b0;
            m_t   = 1'b0;
            if (ld) begin
                if (int'(d_in) > m_lim) begin
                    m_nxt = m_lim;
                    m_set = 1'b1;
                end else begin
                    m_nxt = int'(d_in);
                end
            end else if (en) begin
                if (m_c > m_lim) begin
                    m_nxt = m_lim;
                    m_set = 1'b1;
                end else if (m_es == 0) begin
                    m_nxt = m_c;
                end else if (!mode) begin
                    if (m_c + m_es <= m_lim) begin
                        m_nxt = m_c + m_es;
                        m_t   = (m_nxt == m_lim);
                    end else begin
                        m_nxt = sat ? m_lim : (m_c + m_es) % (m_lim + 1);
                        m_t   = 1'b1;
                        m_set = 1'b1;
                    end
                end else begin
                    if (m_c - m_es >= 0) begin
                        m_nxt = m_c - m_es;
                        m_t   = (m_nxt == 0);
                    end else begin
                        m_nxt = sat ? 0 : (m_c - m_es + m_lim + 1);
                        m_t   = 1'b1;
                        m_set = 1'b1;
                    end
                end
            end
            m_count = m_nxt;
            m_tc    = m_t;
            m_ovf   = m_set | (m_ovf & !ovf_clr);
        end
    end

    logic [31:0] m_count_v;
    assign m_count_v = m_count;

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            total++;
            if (count !== m_count_v[WIDTH-1:0] || tc !== m_tc || ovf !== m_ovf) begin
                bad++;
                $display("FAIL model @%0t: got count=%0d tc=%b ovf=%b want count=%0d tc=%b ovf=%b",
                         $time, count, tc, ovf, m_count, m_tc, m_ovf);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int c, input bit t, input bit o);
        total++;
        if (int'(count) != c || tc !== t || ovf !== o) begin
            bad++;
            $display("FAIL %s: got count=%0d tc=%b ovf=%b want count=%0d tc=%b ovf=%b",
                     name, count, tc, ovf, c, t, o);
        end
    endtask

    task automatic load(input int v, input bit clr_flag);
        ld      = 1'b1;
        en      = 1'b0;
        d_in    = WIDTH'(v);
        ovf_clr = clr_flag;
        tick();
        ld      = 1'b0;
        ovf_clr = 1'b0;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        chk_on  = 1'b0;
        clr     = 1'b1;
        en      = 1'b0;
        ld      = 1'b0;
        mode    = 1'b0;
        d_in    = '0;
        step    = '0;
        limit   = 8'd255;
        sat     = 1'b0;
        ovf_clr = 1'b0;

        // 1: reset and load
        tick();
        tick();
        expect_out("reset", 0, 1'b0, 1'b0);
        chk_on = 1'b1;
        clr    = 1'b0;
        load(9, 1'b0);
        expect_out("load9", 9, 1'b0, 1'b0);

        // 2: increment wrap
        limit = 8'd9;
        load(8, 1'b0);
        en = 1'b1; mode = 1'b0; sat = 1'b0; step = 8'd1;
        tick(); expect_out("inc_to_limit", 9, 1'b1, 1'b0);
        tick(); expect_out("inc_wrap", 0, 1'b1, 1'b1);
        tick(); expect_out("inc_after_wrap", 1, 1'b0, 1'b1);
        en = 1'b0; ovf_clr = 1'b1;
        tick(); expect_out("ovf_clr_idle", 1, 1'b0, 1'b0);
        ovf_clr = 1'b0;

        // 3: saturate up
        limit = 8'd100; sat = 1'b1; step = 8'd7;
        load(98, 1'b0);
        en = 1'b1;
        tick(); expect_out("sat_up", 100, 1'b1, 1'b1);
        tick(); expect_out("sat_up_hold", 100, 1'b1, 1'b1);

        // 4: decrement wrap
        limit = 8'd9; sat = 1'b0; step = 8'd3;
        load(1, 1'b1);
        en = 1'b1; mode = 1'b1;
        tick(); expect_out("dec_wrap", 8, 1'b1, 1'b1);
        tick(); expect_out("dec_after_wrap", 5, 1'b0, 1'b1);

        // 5: ld over en, ovf clear, set beats clear
        mode = 1'b0; step = 8'd1; limit = 8'd150;
        ld = 1'b1; en = 1'b1; d_in = 8'd200;
        tick(); expect_out("ld_clamp_prio", 150, 1'b0, 1'b1);
        ld = 1'b0; en = 1'b0; ovf_clr = 1'b1;
        tick(); expect_out("ovf_clr_alone", 150, 1'b0, 1'b0);
        en = 1'b1;
        tick(); expect_out("set_beats_clr", 0, 1'b1, 1'b1);
        ovf_clr = 1'b0;

        // All-ones limit: modulus 256
        limit = 8'd255; step = 8'd10;
        load(250, 1'b1);
        expect_out("load250", 250, 1'b0, 1'b0);
        en = 1'b1;
        tick(); expect_out("wrap_256", 4, 1'b1, 1'b1);

        // Limit lowered under count
        load(50, 1'b1);
        limit = 8'd20; mode = 1'b1; step = 8'd3; en = 1'b1;
        tick(); expect_out("out_of_range", 20, 1'b0, 1'b1);
        tick(); expect_out("after_oor", 17, 1'b0, 1'b1);

        // Oversized step clamps to limit; zero step holds
        limit = 8'd5; step = 8'd200; mode = 1'b0; sat = 1'b1;
        load(0, 1'b1);
        en = 1'b1;
        tick(); expect_out("step_clamp", 5, 1'b1, 1'b0);
        step = 8'd0;
        tick(); expect_out("step_zero", 5, 1'b0, 1'b0);

        // Decrement: exact landing on 0, then saturate
        mode = 1'b1; step = 8'd2;
        tick(); expect_out("dec_5_3", 3, 1'b0, 1'b0);
        tick(); expect_out("dec_3_1", 1, 1'b0, 1'b0);
        step = 8'd1;
        tick(); expect_out("dec_land0", 0, 1'b1, 1'b0);
        step = 8'd2;
        tick(); expect_out("dec_sat", 0, 1'b1, 1'b1);

        // 6: async reset mid-count
        limit = 8'd255; mode = 1'b0; sat = 1'b0; step = 8'd1;
        load(40, 1'b1);
        en = 1'b1;
        tick(); tick(); tick();
        expect_out("run_up", 43, 1'b0, 1'b0);
        #3;
        clr = 1'b1;
        #1;
        expect_out("async_clr", RESET_VAL, 1'b0, 1'b0);
        tick();
        expect_out("clr_held", RESET_VAL, 1'b0, 1'b0);
        clr = 1'b0;
        tick(); expect_out("resume", RESET_VAL + 1, 1'b0, 1'b0);
        tick(); expect_out("resume2", RESET_VAL + 2, 1'b0, 1'b0);

        en = 1'b0;
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
